// File: rtl/device_register_bank.sv
// Memory-mapped register bank between the 8-bit CPU bus and one peripheral.
// All state updates on the falling clock edge; CPU reads of a register clear its pending event.
module device_register_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter logic [(32'd1 << ADDR_WIDTH)-1:0] RO_MASK  = '0,
    parameter logic [(32'd1 << ADDR_WIDTH)-1:0] IRQ_MASK = '0
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [ADDR_WIDTH-1:0]                           address,
    input  logic                                            enable,
    input  logic                                            mode,
    input  logic [DATA_WIDTH-1:0]                           data_in,
    output wire  [DATA_WIDTH-1:0]                           data_out,
    input  logic [(32'd1 << ADDR_WIDTH)-1:0]                dev_wr_en,
    input  logic [(32'd1 << ADDR_WIDTH)*DATA_WIDTH-1:0]     dev_wr_data,
    output logic [(32'd1 << ADDR_WIDTH)*DATA_WIDTH-1:0]     device_data,
    output logic [(32'd1 << ADDR_WIDTH)-1:0]                cpu_wr_strobe,
    output logic [(32'd1 << ADDR_WIDTH)-1:0]                cpu_rd_strobe,
    output logic                                            irq
);

    localparam int N = 32'd1 << ADDR_WIDTH;

    logic [N-1:0][DATA_WIDTH-1:0] mem_r;
    logic [N-1:0][DATA_WIDTH-1:0] mem_next_s;
    logic [DATA_WIDTH-1:0]        latch_r;
    logic [DATA_WIDTH-1:0]        latch_next_s;
    logic [N-1:0]                 pending_r;
    logic [N-1:0]                 pending_next_s;
    logic [N-1:0]                 wr_strobe_r;
    logic [N-1:0]                 wr_strobe_next_s;
    logic [N-1:0]                 rd_strobe_r;
    logic [N-1:0]                 rd_strobe_next_s;
    logic                         irq_r;
    logic                         cpu_wr_s;
    logic                         cpu_rd_s;

    assign cpu_wr_s = enable & ~mode;
    assign cpu_rd_s = enable & mode;

    // Next-state: CPU access first, peripheral writes last so they win on collisions
    always_comb begin
        mem_next_s       = mem_r;
        latch_next_s     = latch_r;
        pending_next_s   = pending_r;
        wr_strobe_next_s = '0;
        rd_strobe_next_s = '0;

        if (cpu_wr_s) begin
            wr_strobe_next_s[address] = 1'b1;
            if (!RO_MASK[address]) begin
                mem_next_s[address] = data_in;
            end else begin
                mem_next_s[address] = mem_r[address];
            end
        end else begin
            wr_strobe_next_s = '0;
        end

        if (cpu_rd_s) begin
            latch_next_s              = mem_r[address];
            rd_strobe_next_s[address] = 1'b1;
            pending_next_s[address]   = 1'b0;
        end else begin
            latch_next_s = latch_r;
        end

        for (int i = 0; i < N; i++) begin
            if (dev_wr_en[i]) begin
                mem_next_s[i] = dev_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                if (IRQ_MASK[i]) begin
                    pending_next_s[i] = 1'b1;
                end else begin
                    pending_next_s[i] = pending_next_s[i];
                end
            end else begin
                mem_next_s[i] = mem_next_s[i];
            end
        end
    end

    // State registers, updated on the falling bus-clock edge
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r       <= '0;
            latch_r     <= '0;
            pending_r   <= '0;
            wr_strobe_r <= '0;
            rd_strobe_r <= '0;
            irq_r       <= 1'b0;
        end else begin
            mem_r       <= mem_next_s;
            latch_r     <= latch_next_s;
            pending_r   <= pending_next_s;
            wr_strobe_r <= wr_strobe_next_s;
            rd_strobe_r <= rd_strobe_next_s;
            irq_r       <= |pending_next_s;
        end
    end

    // The read latch is the only driver of the shared bus
    assign data_out      = cpu_rd_s ? latch_r : {DATA_WIDTH{1'bz}};
    assign device_data   = mem_r;
    assign cpu_wr_strobe = wr_strobe_r;
    assign cpu_rd_strobe = rd_strobe_r;
    assign irq           = irq_r;

endmodule

// File: tb/tb_device_register_bank.sv
// Directed bench for device_register_bank: reset, RW path, RO protection,
// interrupt lifecycle, same-edge collisions, tri-state and asynchronous reset.
module tb_device_register_bank;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   address = '0;
    logic            enable = 1'b1;
    logic            mode = 1'b1;
    logic [DW-1:0]   data_in = '0;
    wire  [DW-1:0]   data_out;
    logic [N-1:0]    dev_wr_en = '0;
    logic [N*DW-1:0] dev_wr_data = '0;
    logic [N*DW-1:0] device_data;
    logic [N-1:0]    cpu_wr_strobe;
    logic [N-1:0]    cpu_rd_strobe;
    logic            irq;
    logic [N*DW-1:0] exp_view;

    int checks = 0;
    int errors = 0;

    // Undriven bus floats high so a released bus is distinguishable from driven data
    for (genvar b = 0; b < DW; b++) begin : g_pull
        pullup (data_out[b]);
    end

    device_register_bank #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RO_MASK   (16'h0020),
        .IRQ_MASK  (16'h0002)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .enable       (enable),
        .mode         (mode),
        .data_in      (data_in),
        .data_out     (data_out),
        .dev_wr_en    (dev_wr_en),
        .dev_wr_data  (dev_wr_data),
        .device_data  (device_data),
        .cpu_wr_strobe(cpu_wr_strobe),
        .cpu_rd_strobe(cpu_rd_strobe),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [DW-1:0] reg_of(input logic [N*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    initial begin
        // Reset held with a read request active: bus drives zero
        #3;
        check_val("rst_data_out", data_out, 8'h00);
        check_val("rst_irq", irq, 1'b0);
        check_val("rst_view", device_data, '0);
        check_val("rst_strobes", {cpu_wr_strobe, cpu_rd_strobe}, '0);

        step();
        rst_n = 1'b1; address = 4'd3;
        step();
        check_val("rd3_data", data_out, 8'h00);
        check_val("rd3_strobe", cpu_rd_strobe, 16'h0008);

        // CPU write then read of register 2
        mode = 1'b0; address = 4'd2; data_in = 8'hA5;
        #1;
        check_val("wr_bus_released", data_out, 8'hFF);
        step();
        check_val("wr2_view", reg_of(device_data, 2), 8'hA5);
        check_val("wr2_strobe", cpu_wr_strobe, 16'h0004);
        enable = 1'b0;
        step();
        check_val("wr2_strobe_drop", cpu_wr_strobe, 16'h0000);
        check_val("idle_bus_released", data_out, 8'hFF);
        enable = 1'b1; mode = 1'b1; address = 4'd2;
        #1;
        check_val("rd2_first_half", data_out, 8'h00);
        step();
        check_val("rd2_data", data_out, 8'hA5);
        check_val("rd2_strobe", cpu_rd_strobe, 16'h0004);
        enable = 1'b0;
        step();
        check_val("rd2_strobe_drop", cpu_rd_strobe, 16'h0000);

        // Read-only register 5 keeps peripheral value, strobe still pulses
        dev_wr_en = 16'h0020; dev_wr_data[5*DW +: DW] = 8'h11;
        step();
        dev_wr_en = '0; enable = 1'b1; mode = 1'b0; address = 4'd5; data_in = 8'hFF;
        step();
        check_val("ro5_value", reg_of(device_data, 5), 8'h11);
        check_val("ro5_strobe", cpu_wr_strobe, 16'h0020);
        check_val("ro5_no_irq", irq, 1'b0);

        // Interrupt lifecycle on register 1
        enable = 1'b0;
        dev_wr_en = 16'h0002; dev_wr_data[1*DW +: DW] = 8'h42;
        step();
        check_val("irq_set", irq, 1'b1);
        dev_wr_en = '0; enable = 1'b1; mode = 1'b1; address = 4'd1;
        step();
        check_val("irq_rd_data", data_out, 8'h42);
        check_val("irq_cleared", irq, 1'b0);
        enable = 1'b0;
        dev_wr_en = 16'h0001; dev_wr_data[0*DW +: DW] = 8'h77;
        step();
        check_val("irq_unmasked", irq, 1'b0);
        check_val("reg0_view", reg_of(device_data, 0), 8'h77);

        // Same-edge CPU write and peripheral write: peripheral wins
        enable = 1'b1; mode = 1'b0; address = 4'd4; data_in = 8'h10;
        dev_wr_en = 16'h0010; dev_wr_data[4*DW +: DW] = 8'h20;
        step();
        check_val("coll_wr_value", reg_of(device_data, 4), 8'h20);
        check_val("coll_wr_strobe", cpu_wr_strobe, 16'h0010);

        // Same-edge CPU read and peripheral write: old value read, event kept
        mode = 1'b1; address = 4'd1;
        dev_wr_en = 16'h0002; dev_wr_data[1*DW +: DW] = 8'h99;
        step();
        dev_wr_en = '0;
        check_val("coll_rd_old", data_out, 8'h42);
        check_val("coll_rd_irq", irq, 1'b1);
        exp_view = '0;
        exp_view[0*DW +: DW] = 8'h77;
        exp_view[1*DW +: DW] = 8'h99;
        exp_view[2*DW +: DW] = 8'hA5;
        exp_view[4*DW +: DW] = 8'h20;
        exp_view[5*DW +: DW] = 8'h11;
        check_val("full_view", device_data, exp_view);
        check_val("coll_rd_strobe", cpu_rd_strobe, 16'h0002);

        // Asynchronous reset mid-read, no clock edge
        rst_n = 1'b0;
        #1;
        check_val("arst_strobes", {cpu_wr_strobe, cpu_rd_strobe}, '0);
        check_val("arst_irq", irq, 1'b0);
        check_val("arst_view", device_data, '0);
        check_val("arst_data_out", data_out, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
